fixed_add_acc: RTL and testbench
================================

# fixed_add_acc

Parametrised fixed-point adder/accumulator with saturation, overflow/underflow detection and a valid/ready stream interface. It is the successor to the combinational 128-bit Q-format adder: width and fractional bits are generic, the result is registered, and an accumulate mode sums a run of operands (e.g. gradient terms) into one result. It sits between the gradient/difference datapath and the weight-update stage of the linear regressor.

## Interface
- `WIDTH`, default 128: operand, accumulator and result width in bits (two's complement).
- `FRAC`, default 8: fractional bits. Informational only; the arithmetic is format-agnostic.
- `SATURATE`, default 1: 1 clamps results to MAX/MIN on overflow; 0 wraps modulo 2^WIDTH.
- `CNT_W`, default 16: width of the run counter.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous clear of accumulator, run state, counter and sticky flags.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: input beat accepted when `in_valid && in_ready`.
- `mode` in 1: 0 = pair add (a_in + b_in); 1 = accumulate a_in.
- `last` in 1: in mode 1, marks the final operand of a run. Ignored in mode 0.
- `a_in` in WIDTH: operand A, signed.
- `b_in` in WIDTH: operand B, signed. Ignored in mode 1.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `sum_out` out WIDTH: signed result.
- `overflow` out 1: positive overflow occurred in this result. Qualified by `out_valid`.
- `underflow_q` out 1: negative overflow occurred in this result. Qualified by `out_valid`.
- `sticky_ovf` out 1: OR of all `overflow` events since reset or `clear`.
- `sticky_unf` out 1: OR of all `underflow_q` events since reset or `clear`.
- `run_count` out CNT_W: operands accumulated in the current or last-completed run. Saturates at all-ones.

## Operation
- Constants: MAX = 2^(WIDTH-1)-1, MIN = -2^(WIDTH-1).
- Raw add r = x + y, truncated to WIDTH bits.
  - Positive overflow: x and y both non-negative, r negative.
  - Negative overflow: x and y both negative, r non-negative.
  - With SATURATE=1 the result is MAX or MIN respectively; with SATURATE=0 it is r. Flags are raised in both cases.
- FSM states:
  - IDLE: acc = 0, no run open.
  - ACC: run open, acc holds the partial sum.
- Mode 0 beat, in any state: x = a_in, y = b_in. The result goes to the output register with its own flags. acc, state and run_count are untouched.
- Mode 1 beat: x = acc, y = a_in. A per-run flag latch ORs in this beat's overflow/underflow. run_count increments; it is loaded to 1 on the first beat of a run, i.e. in IDLE.
  - last = 0: acc <= result; IDLE -> ACC or stay in ACC. No output.
  - last = 1: output register <= result, and overflow/underflow_q <= the run's OR'd flags including this beat. acc <= 0; state -> IDLE; run latch cleared. run_count holds its final value until the next run starts.
- A single-beat run (IDLE, last = 1) outputs 0 + a_in.
- Intermediate results are saturated before storage when SATURATE=1, so acc never wraps in that mode.
- Sticky flags update when an output is produced.
- `clear` has priority over everything:
  - `in_ready` is 0 that cycle.
  - acc, state, run latch, run_count and sticky flags are reset.
  - A pending output (`out_valid`) is not dropped.

## Timing
- Reset values: `out_valid` 0, `sum_out` 0, `overflow` 0, `underflow_q` 0, `sticky_ovf` 0, `sticky_unf` 0, `run_count` 0, state IDLE, acc 0. `in_ready` is 1 once reset is released.
- `in_ready = !clear && (!out_valid || out_ready)`. This applies to all beats, so non-producing mode-1 beats also stall while the output is blocked; this keeps the logic simple.
- Latency: 1 cycle from an accepted producing beat to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready` = 1.
- Backpressure: while `out_valid && !out_ready`, `sum_out` and the flags are held stable.
- `rst_n` asserted mid-run discards the partial sum and any pending output.

## Structure
- Shared package `fixed_pkg`: `sat_max`/`sat_min` functions of WIDTH, the FSM state enum, and an `add_sat` function returning {result, ovf, unf}.
- One natural sub-module: `fixed_sat_add`, a combinational WIDTH-generic saturating adder with flags, instantiated once. The operand mux selects (a,b) or (acc,a).

## Test plan
Defaults apply (WIDTH=128, FRAC=8), so 1.0 = 256.
- Mode 0, a = 384 (1.5), b = -128 (-0.5) -> next cycle `out_valid`, `sum_out` = 256, both flags 0.
- Mode 0, a = MAX, b = 256, SATURATE=1 -> `sum_out` = MAX, `overflow` = 1, `sticky_ovf` = 1. With SATURATE=0 -> `sum_out` = MIN+255, `overflow` = 1.
- Mode 1 run of 256, 512, -128 with last on the third beat -> single output 640, `run_count` = 3, no output on beats 1-2.
- Mode 1 run MIN, -256, then 512 (last), SATURATE=1 -> acc clamps to MIN, output MIN+512, `underflow_q` = 1.
- Hold `out_ready` = 0 for 3 cycles with a result pending -> `in_ready` = 0, `sum_out` stable, no beat lost when released. Assert `clear` mid-run -> next run starts from 0 and sticky flags are 0.

Source files
------------

// File: rtl/fixed_pkg.sv
// Shared types and arithmetic helpers for the fixed-point adder/accumulator.
// Helpers work on a wide carrier and take the active width as an argument.
package fixed_pkg;

  localparam int MAX_W = 256;

  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  typedef struct packed {
    wide_t res;
    logic  ovf;
    logic  unf;
  } add_res_t;

  function automatic wide_t wmask(input int w);
    if (w >= MAX_W) return '1;
    return (wide_t'(1) << w) - wide_t'(1);
  endfunction

  function automatic wide_t sat_max(input int w);
    return wmask(w) >> 1;
  endfunction

  function automatic wide_t sat_min(input int w);
    return wide_t'(1) << (w - 1);
  endfunction

  function automatic logic sign_of(
    input wide_t v,
    input int    w
  );
    wide_t t;
    t = v >> (w - 1);
    return t[0];
  endfunction

  function automatic add_res_t add_sat(
    input wide_t x,
    input wide_t y,
    input int    w,
    input logic  sat
  );
    add_res_t o;
    wide_t    r;
    logic     sx, sy, sr;
    r     = (x + y) & wmask(w);
    sx    = sign_of(x, w);
    sy    = sign_of(y, w);
    sr    = sign_of(r, w);
    o.ovf = !sx && !sy && sr;
    o.unf = sx && sy && !sr;
    if (sat && o.ovf)      o.res = sat_max(w);
    else if (sat && o.unf) o.res = sat_min(w);
    else                   o.res = r;
    return o;
  endfunction

endpackage

// File: rtl/fixed_add_acc_if.sv
// Stream bundle of the adder/accumulator: input beat, result and status.
// master drives operands and out_ready; slave is the datapath.
interface fixed_add_acc_if #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 16
);

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic             last;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             overflow;
  logic             underflow_q;
  logic             sticky_ovf;
  logic             sticky_unf;
  logic [CNT_W-1:0] run_count;

  modport master (
    output clear, in_valid, mode, last,
    output a_in, b_in, out_ready,
    input  in_ready, out_valid, sum_out,
    input  overflow, underflow_q,
    input  sticky_ovf, sticky_unf,
    input  run_count
  );

  modport slave (
    input  clear, in_valid, mode, last,
    input  a_in, b_in, out_ready,
    output in_ready, out_valid, sum_out,
    output overflow, underflow_q,
    output sticky_ovf, sticky_unf,
    output run_count
  );

endinterface

// File: rtl/fixed_sat_add.sv
// Combinational two's-complement adder with optional clamping.
// Raises ovf/unf on signed overflow whether or not it clamps.
module fixed_sat_add
  import fixed_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int SATURATE = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum,
  output logic             ovf,
  output logic             unf
);

  wide_t    xw, yw;
  add_res_t r;

  always_comb begin
    xw = '0;
    yw = '0;
    xw[WIDTH-1:0] = x;
    yw[WIDTH-1:0] = y;
    r   = add_sat(xw, yw, WIDTH, SATURATE != 0);
    sum = r.res[WIDTH-1:0];
    ovf = r.ovf;
    unf = r.unf;
  end

  if (WIDTH < MAX_W) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^r.res[MAX_W-1:WIDTH];
  end

endmodule

// File: rtl/fixed_add_acc.sv
// Registered fixed-point pair adder / run accumulator with saturation.
// Mode 0 adds a+b; mode 1 sums a run of a_in until last.
module fixed_add_acc
  import fixed_pkg::*;
#(
  parameter int WIDTH    = 128,
  parameter int FRAC     = 8,
  parameter int SATURATE = 1,
  parameter int CNT_W    = 16
) (
  input logic            clk,
  input logic            rst_n,
  fixed_add_acc_if.slave bus
);

  if (FRAC >= WIDTH || WIDTH > MAX_W) begin : g_bad
    $error("fixed_add_acc: bad WIDTH/FRAC");
  end

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] x, y, sum;
  logic             ovf, unf;
  logic             run_ovf, run_unf;
  logic             fire, acc_beat, produce;
  logic             res_ovf, res_unf;

  assign bus.in_ready = !bus.clear &&
                        (!bus.out_valid || bus.out_ready);

  assign fire     = bus.in_valid && bus.in_ready;
  assign acc_beat = fire && bus.mode;
  assign produce  = fire && (!bus.mode || bus.last);

  assign x = bus.mode ? acc      : bus.a_in;
  assign y = bus.mode ? bus.a_in : bus.b_in;

  fixed_sat_add #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_add (
    .x   (x),
    .y   (y),
    .sum (sum),
    .ovf (ovf),
    .unf (unf)
  );

  // A run result reports every overflow seen during the run.
  assign res_ovf = bus.mode ? (run_ovf | ovf) : ovf;
  assign res_unf = bus.mode ? (run_unf | unf) : unf;

  always_comb begin
    state_nx = state;
    if (acc_beat) state_nx = bus.last ? IDLE : ACC;
    if (bus.clear) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      acc             <= '0;
      run_ovf         <= 1'b0;
      run_unf         <= 1'b0;
      bus.run_count   <= '0;
      bus.sticky_ovf  <= 1'b0;
      bus.sticky_unf  <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.sum_out     <= '0;
      bus.overflow    <= 1'b0;
      bus.underflow_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.clear) begin
        acc            <= '0;
        run_ovf        <= 1'b0;
        run_unf        <= 1'b0;
        bus.run_count  <= '0;
        bus.sticky_ovf <= 1'b0;
        bus.sticky_unf <= 1'b0;
      end else begin
        if (acc_beat) begin
          if (state == IDLE)
            bus.run_count <= CNT_W'(1);
          else if (!(&bus.run_count))
            bus.run_count <= bus.run_count + CNT_W'(1);
          if (bus.last) begin
            acc     <= '0;
            run_ovf <= 1'b0;
            run_unf <= 1'b0;
          end else begin
            acc     <= sum;
            run_ovf <= run_ovf | ovf;
            run_unf <= run_unf | unf;
          end
        end
        if (produce) begin
          bus.sticky_ovf <= bus.sticky_ovf | res_ovf;
          bus.sticky_unf <= bus.sticky_unf | res_unf;
        end
      end
      if (produce) begin
        bus.out_valid   <= 1'b1;
        bus.sum_out     <= sum;
        bus.overflow    <= res_ovf;
        bus.underflow_q <= res_unf;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_add_acc.sv
// Bench for fixed_add_acc: saturating and wrapping instances in lockstep.
// Table vectors feed a scoreboard; hand sequences cover stall and clear.
module tb_fixed_add_acc;

  typedef logic [127:0] w_t;

  localparam w_t MAXV = {1'b0, {127{1'b1}}};
  localparam w_t MINV = {1'b1, 127'b0};

  typedef struct {
    logic        mode;
    logic        last;
    w_t          a;
    w_t          b;
    w_t          es;
    logic        eo;
    logic        eu;
    w_t          ew;
    logic        ewo;
    logic        ewu;
    logic [15:0] rc;
  } vec_t;

  typedef struct {
    w_t          s;
    logic        so, su;
    w_t          w;
    logic        wo, wu;
    logic [15:0] rc;
    logic        sso, ssu, swo, swu;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fixed_add_acc_if #(.WIDTH(128), .CNT_W(16)) if_s ();
  fixed_add_acc_if #(.WIDTH(128), .CNT_W(16)) if_w ();

  assign if_w.clear     = if_s.clear;
  assign if_w.in_valid  = if_s.in_valid;
  assign if_w.mode      = if_s.mode;
  assign if_w.last      = if_s.last;
  assign if_w.a_in      = if_s.a_in;
  assign if_w.b_in      = if_s.b_in;
  assign if_w.out_ready = if_s.out_ready;

  fixed_add_acc #(
    .WIDTH(128), .FRAC(8), .SATURATE(1), .CNT_W(16)
  ) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_s)
  );

  fixed_add_acc #(
    .WIDTH(128), .FRAC(8), .SATURATE(0), .CNT_W(16)
  ) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_w)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vt[$];
  logic st_so, st_su, st_wo, st_wu;
  logic [15:0] cur_rc;
  w_t   snap_sum;
  logic snap_ov;

  function automatic w_t sx(input int v);
    return {{96{v[31]}}, v};
  endfunction

  function automatic vec_t mk(
    input logic m, l, input w_t a, b,
    input w_t es, input logic eo, eu,
    input w_t ew, input logic ewo, ewu,
    input int rc
  );
    vec_t v;
    v.mode = m;  v.last = l;
    v.a = a;     v.b = b;
    v.es = es;   v.eo = eo;   v.eu = eu;
    v.ew = ew;   v.ewo = ewo; v.ewu = ewu;
    v.rc = rc[15:0];
    return v;
  endfunction

  task automatic chk(input string nm, input w_t act, input w_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(
    input w_t s, input logic so, su,
    input w_t w, input logic wo, wu
  );
    exp_t e;
    st_so |= so; st_su |= su;
    st_wo |= wo; st_wu |= wu;
    e.s = s;  e.so = so; e.su = su;
    e.w = w;  e.wo = wo; e.wu = wu;
    e.rc = cur_rc;
    e.sso = st_so; e.ssu = st_su;
    e.swo = st_wo; e.swu = st_wu;
    sb.push_back(e);
  endtask

  task automatic mon();
    exp_t e;
    if (if_s.out_valid && if_s.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", if_s.sum_out, 0);
      end else begin
        e = sb.pop_front();
        chk("sat_sum", if_s.sum_out, e.s);
        chk("sat_ovf", if_s.overflow, e.so);
        chk("sat_unf", if_s.underflow_q, e.su);
        chk("sat_sticky_ovf", if_s.sticky_ovf, e.sso);
        chk("sat_sticky_unf", if_s.sticky_unf, e.ssu);
        chk("run_count", if_s.run_count, e.rc);
        chk("wrap_valid", if_w.out_valid, 1);
        chk("wrap_sum", if_w.sum_out, e.w);
        chk("wrap_ovf", if_w.overflow, e.wo);
        chk("wrap_unf", if_w.underflow_q, e.wu);
        chk("wrap_sticky_ovf", if_w.sticky_ovf, e.swo);
        chk("wrap_sticky_unf", if_w.sticky_unf, e.swu);
      end
    end
  endtask

  task automatic cyc(output logic rdy);
    @(negedge clk);
    rdy      = if_s.in_ready;
    snap_sum = if_s.sum_out;
    snap_ov  = if_s.out_valid;
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic m, l, input w_t a, b);
    logic r;
    int   k;
    if_s.in_valid = 1'b1;
    if_s.mode = m;
    if_s.last = l;
    if_s.a_in = a;
    if_s.b_in = b;
    k = 0;
    do begin
      cyc(r);
      k++;
    end while (!r && k < 50);
    if (!r) chk("beat_timeout", 0, 1);
    if_s.in_valid = 1'b0;
  endtask

  task automatic drain();
    logic r;
    for (int k = 0; k < 20 && sb.size() != 0; k++) cyc(r);
    chk("scoreboard_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    vec_t v;
    st_so = 0; st_su = 0; st_wo = 0; st_wu = 0;
    cur_rc = 0;
    if_s.clear = 0;
    if_s.in_valid = 0;
    if_s.mode = 0;
    if_s.last = 0;
    if_s.a_in = '0;
    if_s.b_in = '0;
    if_s.out_ready = 1;

    vt.push_back(mk(0,0,sx(384),sx(-128), sx(256),0,0, sx(256),0,0, 0));
    vt.push_back(mk(0,0,MAXV,sx(256), MAXV,1,0, MINV+255,1,0, 0));
    vt.push_back(mk(1,0,sx(256),0, 0,0,0, 0,0,0, 0));
    vt.push_back(mk(1,0,sx(512),0, 0,0,0, 0,0,0, 0));
    vt.push_back(mk(1,1,sx(-128),0, sx(640),0,0, sx(640),0,0, 3));
    vt.push_back(mk(1,0,MINV,0, 0,0,0, 0,0,0, 0));
    vt.push_back(mk(1,0,sx(-256),0, 0,0,0, 0,0,0, 0));
    vt.push_back(mk(1,1,sx(512),0, MINV+512,0,1, MINV+256,1,1, 3));
    vt.push_back(mk(1,0,sx(100),0, 0,0,0, 0,0,0, 0));
    vt.push_back(mk(0,0,sx(5),sx(7), sx(12),0,0, sx(12),0,0, 1));
    vt.push_back(mk(1,1,sx(1),0, sx(101),0,0, sx(101),0,0, 2));
    vt.push_back(mk(1,1,sx(-300),0, sx(-300),0,0, sx(-300),0,0, 1));
    vt.push_back(mk(0,0,MINV,MINV, MINV,0,1, 0,0,1, 1));
    vt.push_back(mk(0,0,MINV,MAXV, sx(-1),0,0, sx(-1),0,0, 1));
    vt.push_back(mk(0,0,sx(-1),sx(-1), sx(-2),0,0, sx(-2),0,0, 1));

    #23;
    chk("rst_out_valid", if_s.out_valid, 0);
    chk("rst_sum_out", if_s.sum_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", if_s.in_ready, 1);
    chk("rst_out_valid2", if_s.out_valid, 0);
    chk("rst_flags", {if_s.overflow, if_s.underflow_q}, 0);
    chk("rst_sticky", {if_s.sticky_ovf, if_s.sticky_unf}, 0);
    chk("rst_run_count", if_s.run_count, 0);
    @(posedge clk);
    #1;

    foreach (vt[i]) begin
      v = vt[i];
      if (!v.mode || v.last) begin
        cur_rc = v.rc;
        push(v.es, v.eo, v.eu, v.ew, v.ewo, v.ewu);
      end
      beat(v.mode, v.last, v.a, v.b);
    end
    drain();

    if_s.out_ready = 1'b0;
    push(sx(1024), 0, 0, sx(1024), 0, 0);
    beat(0, 0, sx(1000), sx(24));
    if_s.in_valid = 1'b1;
    if_s.mode = 0;
    if_s.a_in = sx(2000);
    if_s.b_in = 0;
    push(sx(2000), 0, 0, sx(2000), 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(r);
      chk("stall_in_ready", r, 0);
      chk("stall_valid", snap_ov, 1);
      chk("stall_sum_hold", snap_sum, sx(1024));
    end
    if_s.out_ready = 1'b1;
    beat(0, 0, sx(2000), 0);
    drain();

    beat(1, 0, sx(256), 0);
    beat(1, 0, sx(256), 0);
    if_s.clear = 1'b1;
    cyc(r);
    chk("clear_in_ready", r, 0);
    if_s.clear = 1'b0;
    st_so = 0; st_su = 0; st_wo = 0; st_wu = 0;
    chk("clear_run_count", if_s.run_count, 0);
    chk("clear_sticky", {if_s.sticky_ovf, if_s.sticky_unf}, 0);
    cur_rc = 1;
    push(sx(100), 0, 0, sx(100), 0, 0);
    beat(1, 1, sx(100), 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
